// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 receiver decoding letter keys into codes A=1..Z=26.
// Define PS2_TYPEMATIC_EN to strobe again on auto-repeat of the held key.
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       key_valid_out,
  output logic [4:0] key_letter_out,
  output logic [4:0] key_held_out,
  output logic       frame_err_out
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_TYPEMATIC_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_t;

  rx_state_t  state;
  logic       clk_s1, clk_s2, clk_prev;
  logic       dat_s1, dat_s2;
  logic [10:0] frame;
  logic [3:0] bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic       brk, ext;

  logic       fall;
  logic       frame_ok;
  logic [7:0] rx_byte;
  logic [4:0] rx_letter;

  function automatic logic [4:0] letter_of(input logic [7:0] code);
    logic [4:0] l;
    case (code)
      8'h1C: l = 5'd1;   8'h32: l = 5'd2;
      8'h21: l = 5'd3;   8'h23: l = 5'd4;
      8'h24: l = 5'd5;   8'h2B: l = 5'd6;
      8'h34: l = 5'd7;   8'h33: l = 5'd8;
      8'h43: l = 5'd9;   8'h3B: l = 5'd10;
      8'h42: l = 5'd11;  8'h4B: l = 5'd12;
      8'h3A: l = 5'd13;  8'h31: l = 5'd14;
      8'h44: l = 5'd15;  8'h4D: l = 5'd16;
      8'h15: l = 5'd17;  8'h2D: l = 5'd18;
      8'h1B: l = 5'd19;  8'h2C: l = 5'd20;
      8'h3C: l = 5'd21;  8'h2A: l = 5'd22;
      8'h1D: l = 5'd23;  8'h22: l = 5'd24;
      8'h35: l = 5'd25;  8'h1A: l = 5'd26;
      default: l = 5'd0;
    endcase
    return l;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  // Frame is shifted in from the top: bit 0 start, 8:1 data, 9 parity, 10 stop
  assign fall      = !clk_s2 && clk_prev;
  assign rx_byte   = frame[8:1];
  assign frame_ok  = !frame[0] && frame[10] && (^frame[9:1]);
  assign rx_letter = letter_of(rx_byte);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      frame          <= '0;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      brk            <= 1'b0;
      ext            <= 1'b0;
      key_valid_out  <= 1'b0;
      key_letter_out <= '0;
      key_held_out   <= '0;
      frame_err_out  <= 1'b0;
    end else begin
      key_valid_out <= 1'b0;
      frame_err_out <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fall) begin
            frame   <= {dat_s2, frame[10:1]};
            bit_cnt <= 4'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            frame   <= {dat_s2, frame[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            frame_err_out <= 1'b1;
            brk           <= 1'b0;
            ext           <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          tmo_cnt <= '0;
          if (!frame_ok) begin
            frame_err_out <= 1'b1;
            brk           <= 1'b0;
            ext           <= 1'b0;
          end else if (rx_byte == 8'hF0) begin
            brk <= 1'b1;
          end else if (rx_byte == 8'hE0) begin
            ext <= 1'b1;
          end else begin
            brk <= 1'b0;
            ext <= 1'b0;
            if (!ext && rx_letter != 5'd0) begin
              if (!brk) begin
                if (rx_letter != key_held_out || REPEAT_EN) begin
                  key_valid_out  <= 1'b1;
                  key_letter_out <= rx_letter;
                end
                key_held_out <= rx_letter;
              end else if (rx_letter == key_held_out) begin
                key_held_out <= 5'd0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Scoreboard bench for ps2_letter_decoder: frames in, letter strobes out.
module tb_ps2_letter_decoder;

  localparam int TMO = 20000;
  localparam int H   = 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic       key_valid_out;
  logic [4:0] key_letter_out;
  logic [4:0] key_held_out;
  logic       frame_err_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_drop = 0;
  int errs  = 0;
  int e0;
  int exp_q[$];

  ps2_letter_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .key_valid_out(key_valid_out),
    .key_letter_out(key_letter_out),
    .key_held_out(key_held_out),
    .frame_err_out(frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && frame_err_out) errs++;
    if (!rst_in && key_valid_out) begin
      if (exp_q.size() == 0) begin
        chk("extra_strobe", int'(key_valid_out), 0);
      end else begin
        chk("strobe_letter", int'(key_letter_out), exp_q.pop_front());
        chk("strobe_latency", cyc - last_drop, 4);
      end
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      ps2_data_in = f[i];
      repeat (H) @(negedge clk_in);
      ps2_clk_in = 1'b0;
      last_drop  = cyc;
      repeat (H) @(negedge clk_in);
      ps2_clk_in = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0);
    logic p;
    p = (~^b) ^ bad_par;
    send_bits({1'b1, p, b, 1'b0}, 11);
    repeat (H) @(negedge clk_in);
  endtask

  task automatic settle;
    repeat (10) @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_valid", int'(key_valid_out), 0);
    chk("rst_letter", int'(key_letter_out), 0);
    chk("rst_held", int'(key_held_out), 0);
    chk("rst_err", int'(frame_err_out), 0);
    rst_in = 1'b0;
    settle();

    exp_q.push_back(1);
    send(8'h1C);
    settle();
    chk("a_letter", int'(key_letter_out), 1);
    chk("a_held", int'(key_held_out), 1);

`ifdef PS2_TYPEMATIC_EN
    exp_q.push_back(1);
`endif
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    settle();
    chk("rep_queue", exp_q.size(), 0);
    chk("brk_held", int'(key_held_out), 0);
    chk("brk_letter", int'(key_letter_out), 1);

    e0 = errs;
    send(8'h15, 1'b1);
    settle();
    chk("par_err", errs - e0, 1);
    chk("par_held", int'(key_held_out), 0);
    exp_q.push_back(26);
    send(8'h1A);
    settle();
    chk("z_letter", int'(key_letter_out), 26);
    chk("z_held", int'(key_held_out), 26);

    send(8'hE0);
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    settle();
    chk("ext_letter", int'(key_letter_out), 26);
    chk("ext_held", int'(key_held_out), 26);
    exp_q.push_back(5);
    send(8'h24);
    settle();
    chk("e_letter", int'(key_letter_out), 5);
    chk("e_held", int'(key_held_out), 5);

    e0 = errs;
    send_bits(11'b000_0011_1000, 5);
    repeat (TMO + 5) @(negedge clk_in);
    chk("tmo_err", errs - e0, 1);
    exp_q.push_back(2);
    send(8'h32);
    settle();
    chk("b_letter", int'(key_letter_out), 2);
    chk("b_held", int'(key_held_out), 2);

    send(8'hF0);
    send(8'h32);
    exp_q.push_back(1);
    send(8'h1C);
    exp_q.push_back(2);
    send(8'h32);
    send(8'hF0);
    send(8'h1C);
    settle();
    chk("stale_held", int'(key_held_out), 2);
    chk("stale_letter", int'(key_letter_out), 2);
    chk("stale_queue", exp_q.size(), 0);

    send_bits(11'b100_0011_1000, 4);
    @(negedge clk_in);
    #1 rst_in = 1'b1;
    #1;
    chk("arst_letter", int'(key_letter_out), 0);
    chk("arst_held", int'(key_held_out), 0);
    chk("arst_valid", int'(key_valid_out), 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    settle();
    exp_q.push_back(1);
    send(8'h1C);
    settle();
    chk("post_letter", int'(key_letter_out), 1);
    chk("post_held", int'(key_held_out), 1);
    chk("end_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
